// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register file: NUM_REGS regs of R/W storage or RO inputs.
// Ports: AXI4-Lite AW/W/B/AR/R, o_regs, i_ro_vals, o_wr_pulse.
// Optional macro AXI4_LITE_REG_FILE_SLVERR_EN: SLVERR on bad accesses.
module axi4_lite_reg_file #(
  parameter int ADDR_BIT_WIDTH = 6,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_awaddr,
  input  logic [2:0]                         i_awprot,
  input  logic                               i_awvalid,
  output logic                               o_awready,
  input  logic [DATA_BIT_WIDTH-1:0]          i_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]        i_wstrb,
  input  logic                               i_wvalid,
  output logic                               o_wready,
  output logic [1:0]                         o_bresp,
  output logic                               o_bvalid,
  input  logic                               i_bready,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_araddr,
  input  logic [2:0]                         i_arprot,
  input  logic                               i_arvalid,
  output logic                               o_arready,
  output logic [DATA_BIT_WIDTH-1:0]          o_rdata,
  output logic [1:0]                         o_rresp,
  output logic                               o_rvalid,
  input  logic                               i_rready,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals,
  output logic [NUM_REGS-1:0]                o_wr_pulse
);

  localparam int SW  = DATA_BIT_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = ADDR_BIT_WIDTH - OFF;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_BIT_WIDTH-1:0] regs_q [NUM_REGS];
  logic [IW-1:0]             aw_idx_q;
  logic [DATA_BIT_WIDTH-1:0] wdata_q;
  logic [SW-1:0]             wstrb_q;
  logic                      aw_done_q;
  logic                      w_done_q;

  logic [IW-1:0]             ar_idx;
  logic [NUM_REGS-1:0]       w_hit;
  logic [NUM_REGS-1:0]       r_hit;
  logic [NUM_REGS-1:0]       w_en;
  logic                      w_err;
  logic                      rd_err;
  logic [DATA_BIT_WIDTH-1:0] rd_val;
  logic [1:0]                w_resp;
  logic [1:0]                r_resp;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      aw_c;
  logic                      w_c;
  logic                      unused;

  assign ar_idx = i_araddr[ADDR_BIT_WIDTH-1:OFF];
  assign aw_hs  = i_awvalid & o_awready;
  assign w_hs   = i_wvalid & o_wready;
  assign aw_c   = aw_done_q | aw_hs;
  assign w_c    = w_done_q | w_hs;

  // Decode by comparison so wide indices never index past NUM_REGS.
  always_comb begin
    w_hit  = '0;
    r_hit  = '0;
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_hit[k] = (aw_idx_q == IW'(k));
      r_hit[k] = (ar_idx == IW'(k));
      if (r_hit[k]) begin
        rd_val = RO_MASK[k]
          ? i_ro_vals[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH]
          : regs_q[k];
      end
    end
  end

  assign w_en   = w_hit & ~RO_MASK;
  assign w_err  = ~|w_en;
  assign rd_err = ~|r_hit;

`ifdef AXI4_LITE_REG_FILE_SLVERR_EN
  assign w_resp = w_err ? 2'b10 : 2'b00;
  assign r_resp = rd_err ? 2'b10 : 2'b00;
  assign unused = ^{i_awprot, i_arprot, i_ro_vals,
                    i_awaddr[OFF-1:0], i_araddr[OFF-1:0]};
`else
  assign w_resp = 2'b00;
  assign r_resp = 2'b00;
  assign unused = ^{i_awprot, i_arprot, i_ro_vals, w_err, rd_err,
                    i_awaddr[OFF-1:0], i_araddr[OFF-1:0]};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state    <= W_IDLE;
      o_awready  <= 1'b0;
      o_wready   <= 1'b0;
      o_bvalid   <= 1'b0;
      o_bresp    <= 2'b00;
      o_wr_pulse <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      o_wr_pulse <= '0;
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_idx_q <= i_awaddr[ADDR_BIT_WIDTH-1:OFF];
          if (w_hs) begin
            wdata_q <= i_wdata;
            wstrb_q <= i_wstrb;
          end
          if (aw_c && w_c) begin
            w_state   <= W_COMMIT;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_c;
            w_done_q  <= w_c;
            o_awready <= ~aw_c;
            o_wready  <= ~w_c;
          end
        end
        W_COMMIT: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (w_en[k]) begin
              for (int b = 0; b < SW; b++) begin
                if (wstrb_q[b]) regs_q[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
              end
            end
          end
          o_wr_pulse <= w_en;
          o_bresp    <= w_resp;
          o_bvalid   <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (i_bready) begin
            o_bvalid  <= 1'b0;
            o_awready <= 1'b1;
            o_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data is sampled from pre-commit storage, so a read on the
  // commit edge returns the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= R_IDLE;
      o_arready <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rdata   <= '0;
      o_rresp   <= 2'b00;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (i_arvalid && o_arready) begin
            o_rdata   <= rd_val;
            o_rresp   <= r_resp;
            o_rvalid  <= 1'b1;
            o_arready <= 1'b0;
            r_state   <= R_RESP;
          end else begin
            o_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (i_rready) begin
            o_rvalid  <= 1'b0;
            o_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign o_regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] =
      RO_MASK[k] ? '0 : regs_q[k];
  end

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Self-checking bench for axi4_lite_reg_file (8 x 32-bit, reg 7 RO).
// Table-driven accesses plus hand sequences for multi-cycle corners.
module tb_axi4_lite_reg_file;

`ifdef AXI4_LITE_REG_FILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic         clk = 0;
  logic         rst_n = 0;
  logic [5:0]   awaddr = 0;
  logic [2:0]   awprot = 0;
  logic         awvalid = 0;
  logic         awready;
  logic [31:0]  wdata = 0;
  logic [3:0]   wstrb = 0;
  logic         wvalid = 0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 0;
  logic [5:0]   araddr = 0;
  logic [2:0]   arprot = 0;
  logic         arvalid = 0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 0;
  logic [255:0] regs;
  logic [255:0] ro_vals = 0;
  logic [7:0]   wr_pulse;

  axi4_lite_reg_file #(
    .ADDR_BIT_WIDTH(6), .DATA_BIT_WIDTH(32),
    .NUM_REGS(8), .RO_MASK(8'h80)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_awaddr(awaddr), .i_awprot(awprot), .i_awvalid(awvalid),
    .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid),
    .o_wready(wready),
    .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arprot(arprot), .i_arvalid(arvalid),
    .o_arready(arready),
    .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid),
    .i_rready(rready),
    .o_regs(regs), .i_ro_vals(ro_vals), .o_wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [8];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [7:0]  pulse;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  function automatic logic [255:0] flat();
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = model[k];
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_delay,
                          input int b_delay, input logic [1:0] resp,
                          input logic [7:0] pulse);
    bit aw_p = 1;
    bit w_p = 1;
    bit aw_f;
    bit w_f;
    bit held = 1;
    int n = 0;
    logic [1:0] e;
    bq.push_back(resp);
    awaddr = addr;
    wdata = data;
    wstrb = strb;
    awvalid = 1;
    while ((aw_p || w_p) && n < 40) begin
      if (w_p && n >= w_delay) wvalid = 1;
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      cyc();
      if (aw_f) begin awvalid = 0; aw_p = 0; end
      if (w_f) begin wvalid = 0; w_p = 0; end
      n++;
    end
    if (aw_p || w_p) begin
      expire("wr_handshake");
      awvalid = 0;
      wvalid = 0;
      void'(bq.pop_front());
      return;
    end
    cyc();
    chk("wr_pulse", wr_pulse, pulse);
    if (pulse != 0) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
    end
    chk("o_regs", regs, flat());
    chk("bvalid_up", bvalid, 1);
    for (int i = 0; i < b_delay; i++) begin
      cyc();
      if (!bvalid) held = 0;
    end
    if (b_delay > 0) chk("bvalid_hold", held, 1);
    bready = 1;
    n = 0;
    while (!bvalid && n < 20) begin cyc(); n++; end
    e = bq.pop_front();
    chk("bresp", bresp, e);
    cyc();
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("pulse_one_cycle", wr_pulse, 0);
    chk("wready_back", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int r_delay);
    bit f = 0;
    int n = 0;
    logic [33:0] e;
    rq.push_back({exp_r, exp_d});
    araddr = addr;
    arvalid = 1;
    while (!f && n < 20) begin
      f = arready;
      cyc();
      n++;
    end
    arvalid = 0;
    if (!f) begin
      expire("ar_handshake");
      void'(rq.pop_front());
      return;
    end
    chk("rvalid_up", rvalid, 1);
    chk("arready_low", arready, 0);
    for (int i = 0; i < r_delay; i++) cyc();
    rready = 1;
    e = rq.pop_front();
    chk("rdata", rdata, e[31:0]);
    chk("rresp", rresp, e[33:32]);
    cyc();
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    for (int k = 0; k < 8; k++) model[k] = 0;
    ro_vals[7*32 +: 32] = 32'hCAFE0001;
    ro_vals[1*32 +: 32] = 32'hFFFFFFFF;

    tbl[0] = '{1, 6'h04, 32'hDEADBEEF, 4'hF, 2'b00, 8'h02};
    tbl[1] = '{0, 6'h04, 32'hDEADBEEF, 4'h0, 2'b00, 8'h00};
    tbl[2] = '{1, 6'h1C, 32'h12345678, 4'hF, ERR,   8'h00};
    tbl[3] = '{0, 6'h1C, 32'hCAFE0001, 4'h0, 2'b00, 8'h00};
    tbl[4] = '{0, 6'h3C, 32'h00000000, 4'h0, ERR,   8'h00};
    tbl[5] = '{1, 6'h3C, 32'h00000055, 4'hF, ERR,   8'h00};
    tbl[6] = '{1, 6'h08, 32'h00000005, 4'hF, 2'b00, 8'h04};
    tbl[7] = '{0, 6'h08, 32'h00000005, 4'h0, 2'b00, 8'h00};
    tbl[8] = '{1, 6'h0E, 32'hAABBCCDD, 4'hF, 2'b00, 8'h08};
    tbl[9] = '{0, 6'h0D, 32'hAABBCCDD, 4'h0, 2'b00, 8'h00};

    repeat (2) cyc();
    chk("rst_outputs",
        {awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp},
        0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regs", regs, 0);
    rst_n = 1;
    chk("ready_low_pre_edge", {awready, wready, arready}, 0);
    cyc();
    chk("ready_after_release", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, i % 2,
                 tbl[i].resp, tbl[i].pulse);
      else
        do_read(tbl[i].addr, tbl[i].data, tbl[i].resp, i % 3);
    end

    // AW at N, W at N+3, partial strobes, bready held off 5 cycles
    do_write(6'h04, 32'h11223344, 4'b0101, 3, 5, 2'b00, 8'h02);
    do_read(6'h04, 32'hDE22BE44, 2'b00, 0);
    chk("ro_slot_zero", regs[7*32 +: 32], 0);

    // Read on the commit edge of a write to the same register
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h5});
    awaddr = 6'h08;
    wdata = 32'h9;
    wstrb = 4'hF;
    awvalid = 1;
    wvalid = 1;
    cyc();
    awvalid = 0;
    wvalid = 0;
    araddr = 6'h08;
    arvalid = 1;
    cyc();
    arvalid = 0;
    model[2] = 32'h9;
    chk("sim_pulse", wr_pulse, 8'h04);
    chk("sim_valids", {bvalid, rvalid}, 2'b11);
    bready = 1;
    rready = 1;
    eb = bq.pop_front();
    er = rq.pop_front();
    chk("sim_bresp", bresp, eb);
    chk("sim_rdata_old", {rresp, rdata}, er);
    cyc();
    bready = 0;
    rready = 0;
    do_read(6'h08, 32'h9, 2'b00, 1);

    // Reset with both response channels pending
    awaddr = 6'h04;
    wdata = 32'h77;
    awvalid = 1;
    wvalid = 1;
    araddr = 6'h04;
    arvalid = 1;
    cyc();
    awvalid = 0;
    wvalid = 0;
    arvalid = 0;
    cyc();
    chk("pre_rst_valids", {bvalid, rvalid}, 2'b11);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valids", {bvalid, rvalid, wr_pulse}, 0);
    chk("async_rst_regs", regs, 0);
    chk("async_rst_ready", {awready, wready, arready}, 0);
    for (int k = 0; k < 8; k++) model[k] = 0;
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    do_write(6'h10, 32'h0BADF00D, 4'hF, 0, 0, 2'b00, 8'h10);
    do_read(6'h04, 32'h0, 2'b00, 0);
    do_read(6'h10, 32'h0BADF00D, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
